// File: rtl/hs_rr_arbiter_if.sv
// Handshake bundle for hs_rr_arbiter: N upstream valid/ready/last/data lanes
// plus one tagged downstream valid/ready stage.
interface hs_rr_arbiter_if #(
  parameter int N      = 4,
  parameter int DATA_W = 8
);
  localparam int ID_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]        in_valid;
  logic [N*DATA_W-1:0] in_data;
  logic [N-1:0]        in_last;
  logic [N-1:0]        in_ready;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic                out_last;
  logic [ID_W-1:0]     out_id;
  logic                out_ready;

  // Environment side: drives requesters and downstream ready.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_id
  );

  // Arbiter side.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_id
  );
endinterface

// File: rtl/hs_rr_arbiter.sv
// Round-robin packet arbiter feeding one registered valid/ready stage.
// A grant is held on one requester from its first accepted beat until its
// last beat is accepted, so packets never interleave. Each output beat is
// tagged with the id of the requester it came from.
module hs_rr_arbiter #(
  parameter int N      = 4,
  parameter int DATA_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  hs_rr_arbiter_if.slave bus
);
  localparam int              ID_W    = (N > 1) ? $clog2(N) : 1;
  localparam int              SCAN_W  = ID_W + 1;
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N - 1);
  localparam logic [SCAN_W-1:0] N_EXT = SCAN_W'(N);

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  lock_state_t       state_r;
  logic [ID_W-1:0]   ptr_r;
  logic [ID_W-1:0]   lock_id_r;
  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic              out_last_r;
  logic [ID_W-1:0]   out_id_r;

  logic              load_en_s;
  logic              accept_s;
  logic              grant_found_s;
  logic [N-1:0]      grant_s;
  logic [ID_W-1:0]   grant_id_s;
  logic [SCAN_W-1:0] scan_idx_s;
  logic [DATA_W-1:0] beat_data_s;
  logic              beat_last_s;

  // The output register can take a new beat when empty or being drained.
  assign load_en_s = !out_valid_r || bus.out_ready;

  // Grant selection: locked requester only, otherwise first valid from ptr.
  always_comb begin
    grant_s       = {N{1'b0}};
    grant_id_s    = {ID_W{1'b0}};
    grant_found_s = 1'b0;
    scan_idx_s    = {SCAN_W{1'b0}};
    if (state_r == LOCKED) begin
      grant_s[lock_id_r] = 1'b1;
      grant_id_s         = lock_id_r;
      grant_found_s      = 1'b1;
    end else begin
      for (int j = 0; j < N; j++) begin
        // Wrap-around scan index: ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
        scan_idx_s = {1'b0, ptr_r} + SCAN_W'(j);
        scan_idx_s = (scan_idx_s >= N_EXT) ? (scan_idx_s - N_EXT) : scan_idx_s;
        if (!grant_found_s && bus.in_valid[scan_idx_s[ID_W-1:0]]) begin
          grant_s[scan_idx_s[ID_W-1:0]] = 1'b1;
          grant_id_s                    = scan_idx_s[ID_W-1:0];
          grant_found_s                 = 1'b1;
        end else begin
          grant_found_s = grant_found_s;
        end
      end
    end
  end

  // Ready only ever reaches the granted requester, and only when the
  // output register can load.
  assign bus.in_ready = load_en_s ? grant_s : {N{1'b0}};
  assign accept_s     = |(bus.in_valid & bus.in_ready);

  // Beat mux from the granted requester's lane.
  always_comb begin
    beat_data_s = bus.in_data[grant_id_s*DATA_W +: DATA_W];
    beat_last_s = bus.in_last[grant_id_s];
  end

  // Lock FSM, round-robin pointer and output register; nothing moves
  // without an accept, so stalls leave the arbitration state untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= UNLOCKED;
      ptr_r       <= {ID_W{1'b0}};
      lock_id_r   <= {ID_W{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
      out_last_r  <= 1'b0;
      out_id_r    <= {ID_W{1'b0}};
    end else begin
      if (load_en_s) begin
        out_valid_r <= accept_s;
        if (accept_s) begin
          out_data_r <= beat_data_s;
          out_last_r <= beat_last_s;
          out_id_r   <= grant_id_s;
        end else begin
          out_data_r <= out_data_r;
        end
      end else begin
        out_valid_r <= out_valid_r;
      end

      if (accept_s) begin
        if (beat_last_s) begin
          state_r <= UNLOCKED;
          ptr_r   <= (grant_id_s == LAST_ID) ? {ID_W{1'b0}}
                                             : grant_id_s + ID_W'(1'b1);
        end else begin
          state_r   <= LOCKED;
          lock_id_r <= grant_id_s;
        end
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_last  = out_last_r;
  assign bus.out_id    = out_id_r;

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Directed bench for hs_rr_arbiter (N=4, DATA_W=8). Inputs change and
// outputs are sampled just after the falling edge.
module tb_hs_rr_arbiter;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  hs_rr_arbiter_if #(.N(4), .DATA_W(8)) bus ();

  hs_rr_arbiter #(.N(4), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input logic l);
    bus.in_data[i*8 +: 8] = d;
    bus.in_last[i]        = l;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic l, input logic [1:0] id);
    check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check_eq({tag, "_data"},  32'(bus.out_data),  32'(d));
    check_eq({tag, "_last"},  32'(bus.out_last),  32'(l));
    check_eq({tag, "_id"},    32'(bus.out_id),    32'(id));
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 4'b0000;
    bus.in_data   = 32'h0000_0000;
    bus.in_last   = 4'b0000;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Idle after reset: nothing granted, output empty.
    for (int i = 0; i < 10; i++) begin
      #1;
      check_eq("idle_valid", 32'(bus.out_valid), 32'd0);
      check_eq("idle_ready", 32'(bus.in_ready),  32'd0);
      next_cyc();
    end
    check_eq("idle_id",   32'(bus.out_id),   32'd0);
    check_eq("idle_data", 32'(bus.out_data), 32'd0);

    // All four hold single-beat packets: strict rotation from ptr=0.
    bus.in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_req(i, 8'(8'hA0 + i), 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq("rot_ready", 32'(bus.in_ready), 32'(4'b0001 << (k % 4)));
      if (k > 0) chk_out("rot", 8'(8'hA0 + (k - 1) % 4), 1'b1, 2'((k - 1) % 4));
      next_cyc();
    end
    bus.in_valid = 4'b0000;
    #1;
    check_eq("rot_end_ready", 32'(bus.in_ready), 32'd0);
    chk_out("rot_wrap", 8'hA0, 1'b1, 2'd0);
    next_cyc();
    #1;
    check_eq("rot_drain", 32'(bus.out_valid), 32'd0);
    next_cyc();

    // ptr=1: req1 3-beat packet locked against req0/req2, then req2, req0.
    bus.in_valid = 4'b0111;
    set_req(0, 8'h01, 1'b1);
    set_req(2, 8'h21, 1'b1);
    set_req(1, 8'h11, 1'b0);
    #1;
    check_eq("pkt_rdy0", 32'(bus.in_ready), 32'b0010);
    next_cyc();
    set_req(1, 8'h12, 1'b0);
    #1;
    check_eq("pkt_rdy1", 32'(bus.in_ready), 32'b0010);
    chk_out("pkt_b0", 8'h11, 1'b0, 2'd1);
    next_cyc();
    set_req(1, 8'h13, 1'b1);
    #1;
    check_eq("pkt_rdy2", 32'(bus.in_ready), 32'b0010);
    chk_out("pkt_b1", 8'h12, 1'b0, 2'd1);
    next_cyc();
    bus.in_valid = 4'b0101;
    #1;
    check_eq("pkt_rdy3", 32'(bus.in_ready), 32'b0100);
    chk_out("pkt_b2", 8'h13, 1'b1, 2'd1);
    next_cyc();
    bus.in_valid = 4'b0001;
    #1;
    check_eq("pkt_rdy4", 32'(bus.in_ready), 32'b0001);
    chk_out("pkt_r2", 8'h21, 1'b1, 2'd2);
    next_cyc();
    bus.in_valid = 4'b0000;
    #1;
    chk_out("pkt_r0", 8'h01, 1'b1, 2'd0);
    next_cyc();
    #1;
    check_eq("pkt_drain", 32'(bus.out_valid), 32'd0);
    next_cyc();

    // ptr=1: req3 locks, drops valid for 2 cycles; req0 must wait.
    bus.in_valid = 4'b1001;
    set_req(0, 8'h0A, 1'b1);
    set_req(3, 8'h31, 1'b0);
    #1;
    check_eq("bub_rdy0", 32'(bus.in_ready), 32'b1000);
    next_cyc();
    bus.in_valid = 4'b0001;
    #1;
    check_eq("bub_rdy1", 32'(bus.in_ready), 32'b1000);
    chk_out("bub_b0", 8'h31, 1'b0, 2'd3);
    next_cyc();
    #1;
    check_eq("bub_rdy2", 32'(bus.in_ready), 32'b1000);
    check_eq("bub_gap1", 32'(bus.out_valid), 32'd0);
    next_cyc();
    bus.in_valid = 4'b1001;
    set_req(3, 8'h32, 1'b1);
    #1;
    check_eq("bub_rdy3", 32'(bus.in_ready), 32'b1000);
    check_eq("bub_gap2", 32'(bus.out_valid), 32'd0);
    next_cyc();
    bus.in_valid = 4'b0001;
    #1;
    check_eq("bub_rdy4", 32'(bus.in_ready), 32'b0001);
    chk_out("bub_b1", 8'h32, 1'b1, 2'd3);
    next_cyc();
    bus.in_valid = 4'b0000;
    #1;
    chk_out("bub_r0", 8'h0A, 1'b1, 2'd0);
    next_cyc();
    #1;
    check_eq("bub_drain", 32'(bus.out_valid), 32'd0);
    next_cyc();

    // ptr=1: beat 0x55 held under backpressure while req2 waits.
    bus.in_valid = 4'b0010;
    set_req(1, 8'h55, 1'b1);
    #1;
    check_eq("bp_rdy0", 32'(bus.in_ready), 32'b0010);
    next_cyc();
    bus.in_valid  = 4'b0100;
    set_req(2, 8'h66, 1'b1);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("bp_stall_rdy", 32'(bus.in_ready), 32'd0);
      chk_out("bp_hold", 8'h55, 1'b1, 2'd1);
      next_cyc();
    end
    bus.out_ready = 1'b1;
    #1;
    check_eq("bp_release_rdy", 32'(bus.in_ready), 32'b0100);
    chk_out("bp_last_hold", 8'h55, 1'b1, 2'd1);
    next_cyc();
    bus.in_valid = 4'b0000;
    #1;
    chk_out("bp_r2", 8'h66, 1'b1, 2'd2);
    next_cyc();
    #1;
    check_eq("bp_drain", 32'(bus.out_valid), 32'd0);
    next_cyc();

    // ptr=3: reset in the middle of a 4-beat packet from req1.
    bus.in_valid = 4'b0010;
    set_req(1, 8'h41, 1'b0);
    #1;
    check_eq("rst_rdy0", 32'(bus.in_ready), 32'b0010);
    next_cyc();
    set_req(1, 8'h42, 1'b0);
    #1;
    chk_out("rst_b0", 8'h41, 1'b0, 2'd1);
    next_cyc();
    bus.in_valid = 4'b0011;
    set_req(0, 8'h0B, 1'b1);
    set_req(1, 8'h43, 1'b0);
    #1;
    check_eq("rst_lock_rdy", 32'(bus.in_ready), 32'b0010);
    chk_out("rst_b1", 8'h42, 1'b0, 2'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_async_data",  32'(bus.out_data),  32'd0);
    check_eq("rst_async_id",    32'(bus.out_id),    32'd0);
    next_cyc();
    rst_n = 1'b1;
    #1;
    check_eq("rst_after_rdy",   32'(bus.in_ready),  32'b0001);
    check_eq("rst_after_valid", 32'(bus.out_valid), 32'd0);
    next_cyc();
    bus.in_valid = 4'b0000;
    #1;
    chk_out("rst_r0", 8'h0B, 1'b1, 2'd0);
    next_cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hs_rr_arbiter.md
Name: hs_rr_arbiter

Overview:
- Round-robin arbiter that shares one registered valid/ready 8-bit pipeline stage among N upstream requesters.
- Each requester sends packets of one or more beats, with the end of a packet marked by in_last.
- A grant stays locked to one requester until that requester's last beat is accepted, so packets are never interleaved.
- Sits in front of a single downstream consumer (next handshake stage) and tags each beat with its source id.

Parameters:
- N, 4, number of requesters; legal range 2..16.
- DATA_W, 8, data width per beat.
- ID_W, derived localparam = clog2(N), width of out_id.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  N  per-requester valid
- in_data  in  N*DATA_W  per-requester data; requester i occupies bits [i*DATA_W +: DATA_W]
- in_last  in  N  per-requester end-of-packet flag, qualified by in_valid
- in_ready  out  N  per-requester ready (one-hot or zero)
- out_valid  out  1  output beat valid
- out_data  out  DATA_W  output beat data
- out_last  out  1  output end-of-packet
- out_id  out  ID_W  index of the requester that produced the beat
- out_ready  in  1  downstream ready

Behaviour:
- Reset (async assert, sync deassert by clk):
  - out_valid=0, out_data=0, out_last=0, out_id=0.
  - Priority pointer ptr=0; lock state UNLOCKED; locked id = 0.
- Output register:
  - load_en = !out_valid || out_ready.
  - A beat is accepted from requester i when in_valid[i] && in_ready[i].
  - On accept, out_data, out_last and out_id load next cycle and out_valid=1.
  - If load_en=1 and no accept occurs, out_valid goes to 0; data, last and id are held.
  - Latency is 1 cycle from accept to output. Full throughput is 1 beat/cycle with out_ready held at 1.
  - While out_valid=1 and out_ready=0, out_data, out_last and out_id are stable.
- in_ready[i] = load_en && grant[i].
  - Combinational paths exist from out_ready and from in_valid to in_ready.
  - in_ready must never assert for an un-granted requester.
- Grant FSM has two states.
  - UNLOCKED:
    - grant = first i with in_valid[i]=1, searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (wrap-around).
    - No valid requester means no grant.
  - LOCKED(k):
    - grant = k only, regardless of other in_valid.
    - If in_valid[k]=0, no beat moves (bubble). The lock is kept and no timeout applies.
- Transitions on an accept from requester i:
  - in_last[i]=0: go to LOCKED(i). If already LOCKED(i), stay.
  - in_last[i]=1: go to UNLOCKED, with ptr = (i+1) mod N.
- No accept: state and ptr unchanged, including when load_en=0. A stall never changes the grant decision's state.
- A single-beat packet (last=1 on its first beat) never enters LOCKED.
- Boundary conditions:
  - All N valid and unlocked: grants rotate ptr-first, each requester served once per N packets.
  - ptr=N-1 wraps to 0.
  - A requester dropping in_valid mid-packet while locked: the arbiter keeps waiting for it.
  - in_valid and in_data from non-granted requesters are ignored. Upstream must hold valid and data until its ready is seen.
  - rst_n asserted mid-packet: immediately returns to reset values, dropping any partially sent packet and the output beat.

Test Plan:
- Reset then idle, all in_valid=0, out_ready=1 -> out_valid=0, in_ready=0000 for 10 cycles; out_id=0, out_data=0.
- All 4 requesters hold single-beat packets (data 0xA0+i, last=1), out_ready=1 -> out_data sequence A0,A1,A2,A3,A0… on consecutive cycles starting 1 cycle after the first accept; out_id 0,1,2,3,0.
- Req1 sends 3-beat packet 0x11,0x12,0x13 (last on 0x13) while req0 and req2 are valid throughout -> output 11,12,13 contiguous with out_id=1 and out_last only on 13; next granted is req2 (ptr=2), then req0.
- Locked req3 deasserts valid for 2 cycles mid-packet while req0 is valid -> 2 bubble cycles with out_valid=0; in_ready[0] stays 0; req3 resumes and completes; req0 is granted next.
- out_valid=1 with beat 0x55 and out_ready=0 for 5 cycles while req2 is valid -> out_data stays 0x55, in_ready=0000; first cycle out_ready=1 accepts req2's beat, and it appears the next cycle.
- rst_n pulsed low in the middle of a 4-beat packet from req1 -> out_valid=0 asynchronously; after release, arbitration starts UNLOCKED from ptr=0 (req0 wins if valid).
